// File: rtl/prng_decimal_display.sv
// Maximal-length Fibonacci LFSR (free-run or single-step) with a sequential double-dabble
// converter driving a 4-digit multiplexed active-low seven-segment display.
module prng_decimal_display #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP_DIV = 50_000_000,
    parameter int unsigned SCAN_DIV = 100_000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             run_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] rnd_o,
    output logic             bcd_valid_o,
    output logic [6:0]       seg_o,
    output logic [3:0]       an_o,
    output logic             dp_o
);

    localparam int unsigned StepW = $clog2(STEP_DIV);
    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    if (WIDTH != 4 && WIDTH != 8 && WIDTH != 12 && WIDTH != 13) begin : g_bad_width
        $error("prng_decimal_display: WIDTH must be 4, 8, 12 or 13");
    end
    if (STEP_DIV <= WIDTH + 3) begin : g_bad_step_div
        $error("prng_decimal_display: STEP_DIV must exceed WIDTH+3");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $error("prng_decimal_display: SCAN_DIV must be at least 1");
    end

    function automatic logic [WIDTH-1:0] tap_mask();
        logic [31:0] m;
        m = 32'h0;
        case (WIDTH)
            4:       m = 32'h0000_000C;
            8:       m = 32'h0000_00B8;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            default: m = 32'h0;
        endcase
        return m[WIDTH-1:0];
    endfunction

    localparam logic [WIDTH-1:0] TapMask = tap_mask();
    localparam logic [WIDTH-1:0] RndOne  = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} conv_state_e;

    logic [WIDTH-1:0] rnd_q, rnd_d, rnd_next;
    logic [StepW-1:0] step_cnt_q, step_cnt_d;
    logic             upd;
    logic             conv_req_q;

    conv_state_e      state_q, state_d;
    logic             pend_q, pend_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [15:0]      bcd_q, bcd_d, bcd_adj;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [15:0]      digits_q, digits_d;
    logic             valid_q, valid_d;

    logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       blank;

    assign rnd_next = {rnd_q[WIDTH-2:0], ^(rnd_q & TapMask)};

    // LFSR update: set beats advance; zero seed would lock up, so it maps to 1.
    always_comb begin
        rnd_d      = rnd_q;
        step_cnt_d = step_cnt_q;
        upd        = 1'b0;
        if (set_i) begin
            rnd_d      = (seed_i == '0) ? RndOne : seed_i;
            step_cnt_d = '0;
            upd        = 1'b1;
        end else if (run_i) begin
            if (step_cnt_q == StepW'(STEP_DIV - 1)) begin
                step_cnt_d = '0;
                rnd_d      = rnd_next;
                upd        = 1'b1;
            end else begin
                step_cnt_d = step_cnt_q + 1'b1;
            end
        end else begin
            step_cnt_d = '0;
            if (step_i) begin
                rnd_d = rnd_next;
                upd   = 1'b1;
            end
        end
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        sh_d     = sh_q;
        digits_d = digits_q;
        valid_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (conv_req_q) state_d = StLoad;
            end
            StLoad: begin
                sh_d    = rnd_q;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = StShift;
                if (conv_req_q) pend_d = 1'b1;
            end
            StShift: begin
                bcd_d = (bcd_adj << 1) | {15'b0, sh_q[WIDTH-1]};
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(WIDTH - 1)) state_d = StDone;
                if (conv_req_q) pend_d = 1'b1;
            end
            StDone: begin
                digits_d = bcd_q;
                valid_d  = 1'b1;
                if (pend_q || conv_req_q) begin
                    state_d = StLoad;
                    pend_d  = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from next-state so they move only on scan advance or digit update.
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
        blank[0] = 1'b0;
        blank[1] = BLANK_LZ && (digits_d[15:4] == 12'h0);
        blank[2] = BLANK_LZ && (digits_d[15:8] == 8'h0);
        blank[3] = BLANK_LZ && (digits_d[15:12] == 4'h0);
        seg_d    = blank[idx_d] ? 7'h7F : seg_decode(digits_d[{idx_d, 2'b00} +: 4]);
        an_d     = ~(4'b0001 << idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_q      <= RndOne;
            step_cnt_q <= '0;
            conv_req_q <= 1'b0;
            state_q    <= StIdle;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            sh_q       <= '0;
            digits_q   <= 16'h0001;
            valid_q    <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            seg_q      <= 7'h79;
            an_q       <= 4'b1110;
        end else begin
            rnd_q      <= rnd_d;
            step_cnt_q <= step_cnt_d;
            conv_req_q <= upd;
            state_q    <= state_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            sh_q       <= sh_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign rnd_o       = rnd_q;
    assign bcd_valid_o = valid_q;
    assign seg_o       = seg_q;
    assign an_o        = an_q;
    assign dp_o        = 1'b1;

endmodule
